// File: rtl/transmitter.sv
// Sending end of a two-phase bundled-data channel: buffers words in a small FIFO,
// launches each word on outData, toggles outR after a setup delay and waits for the synchronised ack.
module transmitter #(
   parameter int DW          = 8,
   parameter int DEPTH       = 4,
   parameter int SETUP_CYC   = 2,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   output logic          outR,
   output logic [DW-1:0] outData,
   input  logic          outA,
   output logic          o_busy,
   output logic          o_timeout,
   output logic          o_proto_err
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = AW + 1;
   localparam int CW   = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
   localparam int TW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(DEPTH);
   localparam logic [CW-1:0]   SETUP_LOAD = CW'(SETUP_CYC - 1);
   localparam logic [TW-1:0]   TMAX       = TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WAIT  = 2'd2
   } txState_t;

   txState_t state;
   txState_t nextState;

   logic [DW-1:0]          mem [DEPTH];
   logic [AW-1:0]          wrPtr;
   logic [AW-1:0]          rdPtr;
   logic [CNTW-1:0]        count;
   logic                   readyEn;
   logic [SYNC_STAGES-1:0] ackSync;
   logic                   ackS;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          nextCnt;
   logic [TW-1:0]          tcnt;
   logic [TW-1:0]          nextTcnt;
   logic                   push;
   logic                   pop;
   logic                   loadWord;
   logic                   toggleReq;
   logic                   protoHit;
   logic                   timeoutHit;

   // o_ready is held low through reset and only rises on the first edge afterwards.
   assign o_ready = readyEn & (count != FULL_CNT);
   assign push    = i_valid & o_ready;
   assign ackS    = ackSync[SYNC_STAGES-1];
   assign o_busy  = (count != '0) | (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         readyEn <= 1'b0;
      end else begin
         readyEn <= 1'b1;
      end
   end

   // Storage array carries no reset; occupancy and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // The ack comes from another timing domain, so it only reaches the FSM through this chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ackSync <= '0;
      end else begin
         ackSync <= {ackSync[SYNC_STAGES-2:0], outA};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // The head word stays in the FIFO until its ack returns, so a full FIFO still counts the word on the wire.
   always_comb begin
      nextState  = state;
      nextCnt    = cnt;
      nextTcnt   = tcnt;
      pop        = 1'b0;
      loadWord   = 1'b0;
      toggleReq  = 1'b0;
      protoHit   = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE: begin
            protoHit = (ackS != outR);
            if (count != '0) begin
               loadWord  = 1'b1;
               nextCnt   = SETUP_LOAD;
               nextState = SETUP;
            end
         end
         SETUP: begin
            protoHit = (ackS != outR);
            if (cnt == '0) begin
               toggleReq = 1'b1;
               nextTcnt  = '0;
               nextState = WAIT;
            end else begin
               nextCnt = cnt - CW'(1);
            end
         end
         WAIT: begin
            if (ackS == outR) begin
               pop       = 1'b1;
               nextState = IDLE;
            end else begin
               if (tcnt != TMAX) begin
                  nextTcnt = tcnt + TW'(1);
               end
               if ((TIMEOUT_CYC != 0) && (tcnt == TMAX)) begin
                  timeoutHit = 1'b1;
               end
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // outData only changes on an IDLE load, which keeps it stable for the whole handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outData     <= '0;
         outR        <= 1'b0;
         cnt         <= '0;
         tcnt        <= '0;
         o_timeout   <= 1'b0;
         o_proto_err <= 1'b0;
      end else begin
         cnt  <= nextCnt;
         tcnt <= nextTcnt;
         if (loadWord) begin
            outData <= mem[rdPtr];
         end
         if (toggleReq) begin
            outR <= ~outR;
         end
         if (timeoutHit) begin
            o_timeout <= 1'b1;
         end
         if (protoHit) begin
            o_proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter: directed steps plus randomized streams against a
// queue-based model of the words the receiver should see, in push order.
module tb_transmitter;

   localparam int DW          = 8;
   localparam int DEPTH       = 4;
   localparam int SETUP_CYC   = 2;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT_CYC = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [DW-1:0] i_data = '0;
   logic          outR;
   logic [DW-1:0] outData;
   logic          outA;
   logic          o_busy;
   logic          o_timeout;
   logic          o_proto_err;

   int checks = 0;
   int passes = 0;

   bit ackStall     = 1'b0;
   bit ackManual    = 1'b0;
   bit ackManualVal = 1'b0;
   int ackDelay     = 2;

   logic [DW-1:0] rxQ[$];
   logic [DW-1:0] expQ[$];
   int            toggles = 0;
   int            rxBase  = 0;
   int            togBase = 0;

   transmitter #(
      .DW(DW), .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC),
      .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
      .outR(outR), .outData(outData), .outA(outA), .o_busy(o_busy),
      .o_timeout(o_timeout), .o_proto_err(o_proto_err)
   );

   always #5 clk = ~clk;

   // Receiver stand-in: copies outR onto outA after ackDelay cycles, or follows a manual value.
   initial begin : receiverModel
      int waitCnt;
      waitCnt = 0;
      outA = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            outA = 1'b0;
            waitCnt = 0;
         end else if (ackManual) begin
            outA = ackManualVal;
         end else if ((outR !== outA) && !ackStall) begin
            waitCnt++;
            if (waitCnt >= ackDelay) begin
               outA = outR;
               waitCnt = 0;
            end
         end else begin
            waitCnt = 0;
         end
      end
   end

   // Every outR transition delivers whatever outData holds at that moment.
   initial begin : monitor
      logic prevR;
      prevR = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevR = 1'b0;
         end else if (outR !== prevR) begin
            rxQ.push_back(outData);
            toggles++;
            prevR = outR;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: observed=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) begin
         passes++;
      end else begin
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Must be called at a negedge; returns at a negedge after the word is accepted or the budget runs out.
   task automatic applyStimulus(input logic [DW-1:0] d, input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      i_valid = 1'b1;
      i_data  = d;
      for (int n = 0; n < budget && !ok; n++) begin
         if (o_ready === 1'b1) begin
            ok = 1'b1;
         end
         @(negedge clk);
      end
      i_valid = 1'b0;
      if (ok) begin
         expQ.push_back(d);
      end else begin
         checkOutput({tag, " accepted"}, 32'(ok), 32'd1);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      i_valid = 1'b0;
      i_data = '0;
      ackStall = 1'b0;
      ackManual = 1'b0;
      ackManualVal = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      expQ.delete();
      rxBase  = rxQ.size();
      togBase = toggles;
   endtask

   task automatic waitIdle(input int budget, input string tag);
      int n;
      n = 0;
      while ((o_busy !== 1'b0) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " idle"}, 32'(o_busy), 32'd0);
   endtask

   task automatic checkDelivery(input string tag);
      checkOutput({tag, " count"}, 32'(rxQ.size() - rxBase), 32'(expQ.size()));
      for (int i = 0; i < expQ.size(); i++) begin
         if (rxBase + i < rxQ.size()) begin
            checkOutput({tag, " word"}, 32'(rxQ[rxBase + i]), 32'(expQ[i]));
         end
      end
   endtask

   initial begin : mainSeq
      int nWords;
      logic [DW-1:0] w;

      // Reset pulse while a word sits in SETUP.
      doReset();
      checkOutput("post-reset o_ready", 32'(o_ready), 32'd1);
      applyStimulus(8'h5A, 1, "reset word");
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst outR", 32'(outR), 32'd0);
      checkOutput("rst outData", 32'(outData), 32'd0);
      checkOutput("rst o_ready", 32'(o_ready), 32'd0);
      checkOutput("rst o_busy", 32'(o_busy), 32'd0);
      checkOutput("rst o_timeout", 32'(o_timeout), 32'd0);
      checkOutput("rst o_proto_err", 32'(o_proto_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOutput("o_ready before first edge", 32'(o_ready), 32'd0);
      @(negedge clk);
      checkOutput("o_ready after first edge", 32'(o_ready), 32'd1);
      checkOutput("lost word busy", 32'(o_busy), 32'd0);
      checkOutput("lost word outR", 32'(outR), 32'd0);

      // Single word with a 3-cycle receiver.
      doReset();
      ackDelay = 3;
      applyStimulus(8'hA5, 1, "single");
      @(negedge clk);
      checkOutput("single outData edge1", 32'(outData), 32'hA5);
      checkOutput("single outR edge1", 32'(outR), 32'd0);
      @(negedge clk);
      checkOutput("single outR edge2", 32'(outR), 32'd0);
      @(negedge clk);
      checkOutput("single outR edge3", 32'(outR), 32'd1);
      checkOutput("single busy", 32'(o_busy), 32'd1);
      waitIdle(40, "single");
      checkOutput("single outData held", 32'(outData), 32'hA5);
      checkDelivery("single");

      // Burst against a stalled receiver.
      doReset();
      ackStall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(DW'(i), 1, "burst fill");
      end
      checkOutput("burst full o_ready", 32'(o_ready), 32'd0);
      i_valid = 1'b1;
      i_data  = 8'h05;
      repeat (5) @(negedge clk);
      checkOutput("burst still full", 32'(o_ready), 32'd0);
      i_valid = 1'b0;
      checkOutput("burst one toggle", 32'(toggles - togBase), 32'd1);
      checkOutput("burst outData head", 32'(outData), 32'h01);
      ackStall = 1'b0;
      applyStimulus(8'h05, 100, "burst 05");
      applyStimulus(8'h06, 100, "burst 06");
      waitIdle(200, "burst");
      checkDelivery("burst");
      checkOutput("burst toggles", 32'(toggles - togBase), 32'd6);
      checkOutput("burst outR end", 32'(outR), 32'd0);

      // Push and pop on the same edge at occupancy 3.
      doReset();
      ackManual = 1'b1;
      ackManualVal = 1'b0;
      applyStimulus(8'h11, 1, "simul");
      applyStimulus(8'h22, 1, "simul");
      applyStimulus(8'h33, 1, "simul");
      repeat (5) @(negedge clk);
      checkOutput("simul outR waiting", 32'(outR), 32'd1);
      checkOutput("simul o_ready at 3", 32'(o_ready), 32'd1);
      #2 ackManualVal = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(8'h44, 1, "simul push-pop");
      checkOutput("simul o_ready after push-pop", 32'(o_ready), 32'd1);
      applyStimulus(8'h55, 1, "simul fill");
      checkOutput("simul o_ready full", 32'(o_ready), 32'd0);
      ackManual = 1'b0;
      ackDelay = 2;
      waitIdle(300, "simul");
      checkDelivery("simul");
      checkOutput("simul proto", 32'(o_proto_err), 32'd0);

      // Random stream across several pointer wraps with varying receiver delay.
      doReset();
      nWords = 21;
      for (int i = 0; i < nWords; i++) begin
         w = DW'($urandom);
         ackDelay = int'($urandom_range(1, 4));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(w, 200, "random");
      end
      waitIdle(500, "random");
      checkDelivery("random");
      checkOutput("random outR parity", 32'(outR), 32'(nWords % 2));
      checkOutput("random timeout", 32'(o_timeout), 32'd0);

      // Ack withheld in WAIT long enough to trip the timeout.
      doReset();
      ackManual = 1'b1;
      ackManualVal = 1'b0;
      applyStimulus(8'h77, 1, "timeout");
      repeat (200) @(negedge clk);
      checkOutput("timeout early", 32'(o_timeout), 32'd0);
      checkOutput("timeout busy", 32'(o_busy), 32'd1);
      repeat (100) @(negedge clk);
      checkOutput("timeout set", 32'(o_timeout), 32'd1);
      checkOutput("timeout outData held", 32'(outData), 32'h77);
      ackManual = 1'b0;
      waitIdle(50, "timeout");
      checkOutput("timeout sticky", 32'(o_timeout), 32'd1);
      checkDelivery("timeout");

      // Ack toggled with nothing outstanding.
      doReset();
      checkOutput("proto clear", 32'(o_proto_err), 32'd0);
      ackManual = 1'b1;
      ackManualVal = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("proto set", 32'(o_proto_err), 32'd1);
      checkOutput("proto no timeout", 32'(o_timeout), 32'd0);
      applyStimulus(8'h88, 1, "proto");
      waitIdle(50, "proto");
      checkDelivery("proto");
      checkOutput("proto sticky", 32'(o_proto_err), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
